accel_vec_accumulator: RTL
==========================

ACCEL_VEC_ACCUMULATOR -- requirements
Module: accel_vec_accumulator

Interface
REQ-001 Parameters (name, default, meaning): DATA_WIDTH 256, bus/vector width; ADDR_WIDTH 32, byte address width; CTRL_WIDTH 32, control data width; ELEM_WIDTH 16, signed lane width; LEN_WIDTH 16, beat-count width; SATURATE 0, 0=wrapping add, 1=saturating add.
REQ-002 LANES = DATA_WIDTH/ELEM_WIDTH; DATA_WIDTH SHALL be an integer multiple of ELEM_WIDTH, elaboration error otherwise.
REQ-003 Ports (name, direction, width, meaning): clk in 1, clock; rst_n in 1, reset.
REQ-004 Control port: control_cyc_o, control_stb_o, control_we_o in 1; control_ack_i out 1; control_addr_o in ADDR_WIDTH; control_mosi_o in CTRL_WIDTH; control_miso_i out CTRL_WIDTH; Wishbone classic slave.
REQ-005 done_interrupt_o out 1, completion interrupt, level.
REQ-006 Samples port (read master): samples_cyc_o, samples_stb_o, samples_we_o out 1; samples_ack_i in 1; samples_addr_o out ADDR_WIDTH; samples_mosi_o out DATA_WIDTH; samples_miso_i in DATA_WIDTH; samples_cti_o out 3; samples_bte_o out 2.
REQ-007 Cache port (write master): cache_cyc_o, cache_stb_o, cache_we_o out 1; cache_ack_i in 1; cache_addr_o out ADDR_WIDTH; cache_mosi_o out DATA_WIDTH; cache_miso_i in DATA_WIDTH; cache_cti_o out 3; cache_bte_o out 2.
REQ-008 One clock, clk; reset rst_n is synchronous and active-low.

Function
REQ-009 Register map, decoded on control_addr_o[4:2]: 0 CTRL (bit0 START write-1 pulse, reads 0; bit1 IRQ_EN); 1 STATUS (bit0 BUSY RO; bit1 DONE, write-1-clear); 2 SRC; 3 DST; 4 LEN (low LEN_WIDTH bits); 5 PARAM RO = {LANES[15:0], ELEM_WIDTH[15:0]}; others read 0, writes ignored.
REQ-010 control_ack_i pulses high exactly one cycle after each cycle with cyc&stb&!ack; read data valid in the ack cycle; back-to-back accesses ack every other cycle.
REQ-011 FSM states: IDLE, READ, WRITE, DONE.
REQ-012 IDLE->READ on START with LEN!=0; IDLE->DONE on START with LEN==0 (no bus traffic, accumulator = 0, no cache write).
REQ-013 On START the lane accumulator clears to 0 and SRC/DST/LEN are latched; register writes to SRC/DST/LEN while BUSY are ignored; START while BUSY is ignored.
REQ-014 READ: samples_cyc_o and samples_stb_o high continuously from first to last beat; samples_we_o=0; beat i address = SRC + i*(DATA_WIDTH/8); address advances in the cycle after each ack.
REQ-015 samples_cti_o = 3'b010 for beats 0..LEN-2, 3'b111 on beat LEN-1 (and on the single beat when LEN==1); samples_bte_o = 2'b00 always.
REQ-016 Per ack, lane k (bits k*ELEM_WIDTH +: ELEM_WIDTH) acc[k] <= acc[k] + miso[k], signed; SATURATE=0 wraps modulo 2^ELEM_WIDTH; SATURATE=1 clamps to [-2^(ELEM_WIDTH-1), 2^(ELEM_WIDTH-1)-1].
REQ-017 After the LEN-th ack, samples_cyc_o/stb_o drop next cycle, FSM enters WRITE.
REQ-018 WRITE: single beat, cache_cyc_o=cache_stb_o=cache_we_o=1, cache_addr_o=DST, cache_mosi_o=accumulator, cache_cti_o=3'b111, cache_bte_o=2'b00; held until cache_ack_i; WRITE->DONE the cycle after ack.
REQ-019 DONE: sets STATUS.DONE, clears BUSY, returns to IDLE next cycle; BUSY=1 in READ and WRITE only.
REQ-020 done_interrupt_o = STATUS.DONE & IRQ_EN, registered; cleared by writing 1 to STATUS bit1 or IRQ_EN=0; STATUS.DONE set and clear in same cycle: set wins.
REQ-021 Stall: with ack held low, master outputs hold indefinitely; no timeout.
REQ-022 Address overflow wraps modulo 2^ADDR_WIDTH.
REQ-023 Idle master outputs: cyc/stb/we 0, addr 0, mosi 0, cti 3'b000, bte 2'b00.

Reset
REQ-024 rst_n low at a clk edge: FSM IDLE, all registers, accumulator, STATUS, IRQ_EN 0; all outputs 0 next cycle including mid-burst (bus cycle abandoned, no write issued).

Verification
REQ-025 SRC=0x1000, DST=0x2000, LEN=3, all lanes of beats = 1,2,3 -> samples addrs 0x1000/0x1020/0x1040, cti 010,010,111; cache write at 0x2000 all lanes 6; DONE=1.
REQ-026 SATURATE=0, LEN=2, lane0 = 0x7FFF then 0x0001 -> lane0 result 0x8000; SATURATE=1 same stimulus -> 0x7FFF; lane0 0x8000+0xFFFF with SATURATE=1 -> 0x8000.
REQ-027 LEN=0, START, IRQ_EN=1 -> no samples/cache cycles, DONE=1, done_interrupt_o=1 within 3 cycles; write 0x2 to STATUS -> done_interrupt_o=0.
REQ-028 LEN=4, samples_ack_i stalled 5 cycles on beat 2, START and SRC write during busy -> addr/stb held, ignored writes, final result and 4 beats unchanged.
REQ-029 rst_n low during beat 1 of LEN=4 -> cyc/stb 0 next cycle, STATUS=0, no cache write; new START afterward completes normally.
REQ-030 Control read of PARAM with defaults -> 0x00100010; read of addr index 7 -> 0; ack one cycle after stb.

Source files
------------

// File: rtl/accel_vec_accumulator.sv
// Vector accumulator: bursts LEN beats from a source address, adds each beat
// lane-wise (signed, wrapping or saturating) into an accumulator, then writes
// the accumulated vector to a destination address with a single-beat write.
module accel_vec_accumulator #(
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 32,
  parameter int CTRL_WIDTH = 32,
  parameter int ELEM_WIDTH = 16,
  parameter int LEN_WIDTH  = 16,
  parameter int SATURATE   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  control_cyc_o,
  input  logic                  control_stb_o,
  input  logic                  control_we_o,
  output logic                  control_ack_i,
  input  logic [ADDR_WIDTH-1:0] control_addr_o,
  input  logic [CTRL_WIDTH-1:0] control_mosi_o,
  output logic [CTRL_WIDTH-1:0] control_miso_i,
  output logic                  done_interrupt_o,
  output logic                  samples_cyc_o,
  output logic                  samples_stb_o,
  output logic                  samples_we_o,
  input  logic                  samples_ack_i,
  output logic [ADDR_WIDTH-1:0] samples_addr_o,
  output logic [DATA_WIDTH-1:0] samples_mosi_o,
  input  logic [DATA_WIDTH-1:0] samples_miso_i,
  output logic [2:0]            samples_cti_o,
  output logic [1:0]            samples_bte_o,
  output logic                  cache_cyc_o,
  output logic                  cache_stb_o,
  output logic                  cache_we_o,
  input  logic                  cache_ack_i,
  output logic [ADDR_WIDTH-1:0] cache_addr_o,
  output logic [DATA_WIDTH-1:0] cache_mosi_o,
  input  logic [DATA_WIDTH-1:0] cache_miso_i,
  output logic [2:0]            cache_cti_o,
  output logic [1:0]            cache_bte_o
);

  localparam int LANES      = DATA_WIDTH / ELEM_WIDTH;
  localparam int BEAT_BYTES = DATA_WIDTH / 8;

  generate
    if (DATA_WIDTH % ELEM_WIDTH != 0) begin : g_width_check
      $error("DATA_WIDTH must be an integer multiple of ELEM_WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t                  state;
  logic                    ctrl_ack_q;
  logic [CTRL_WIDTH-1:0]   ctrl_miso_q;
  logic [CTRL_WIDTH-1:0]   rd_data;
  logic                    irq_en;
  logic                    done_q;
  logic                    irq_q;
  logic [ADDR_WIDTH-1:0]   src_q;
  logic [ADDR_WIDTH-1:0]   dst_q;
  logic [LEN_WIDTH-1:0]    len_q;
  logic [LEN_WIDTH-1:0]    beat_cnt;
  logic [DATA_WIDTH-1:0]   acc;
  logic [DATA_WIDTH-1:0]   acc_sum;
  logic                    rd_cyc_q;
  logic [ADDR_WIDTH-1:0]   rd_addr_q;
  logic [2:0]              rd_cti_q;
  logic                    wr_cyc_q;
  logic [ADDR_WIDTH-1:0]   wr_addr_q;
  logic [DATA_WIDTH-1:0]   wr_data_q;
  logic                    unused_ok;

  // One lane add; the sum is formed one bit wider so overflow is visible.
  function automatic logic signed [ELEM_WIDTH-1:0] lane_add(
    input logic signed [ELEM_WIDTH-1:0] a,
    input logic signed [ELEM_WIDTH-1:0] b
  );
    logic signed [ELEM_WIDTH:0] sum;
    sum = $signed({a[ELEM_WIDTH-1], a}) + $signed({b[ELEM_WIDTH-1], b});
    if (SATURATE != 0 && sum[ELEM_WIDTH] != sum[ELEM_WIDTH-1]) begin
      lane_add = sum[ELEM_WIDTH] ? {1'b1, {(ELEM_WIDTH-1){1'b0}}}
                                 : {1'b0, {(ELEM_WIDTH-1){1'b1}}};
    end else begin
      lane_add = sum[ELEM_WIDTH-1:0];
    end
  endfunction

  wire [2:0] reg_idx  = control_addr_o[4:2];
  wire       ctrl_req = control_cyc_o & control_stb_o & ~ctrl_ack_q;
  wire       ctrl_wr  = ctrl_req & control_we_o;
  wire       busy     = (state == READ) || (state == WRITE);
  wire       start    = ctrl_wr && (reg_idx == 3'd0) && control_mosi_o[0] && !busy;
  wire       done_clr = ctrl_wr && (reg_idx == 3'd1) && control_mosi_o[1];
  wire       done_set = (start && (len_q == '0)) || ((state == WRITE) && cache_ack_i);
  wire       last_beat = (beat_cnt == len_q - LEN_WIDTH'(1));

  assign unused_ok = ^{cache_miso_i, control_addr_o};

  // Lane-wise sum of the accumulator and the incoming beat.
  always_comb begin
    acc_sum = '0;
    for (int k = 0; k < LANES; k++) begin
      acc_sum[k*ELEM_WIDTH +: ELEM_WIDTH] =
        lane_add(acc[k*ELEM_WIDTH +: ELEM_WIDTH], samples_miso_i[k*ELEM_WIDTH +: ELEM_WIDTH]);
    end
  end

  // Register read multiplexer.
  always_comb begin
    rd_data = '0;
    case (reg_idx)
      3'd0: rd_data = CTRL_WIDTH'({irq_en, 1'b0});
      3'd1: rd_data = CTRL_WIDTH'({done_q, busy});
      3'd2: rd_data = CTRL_WIDTH'(src_q);
      3'd3: rd_data = CTRL_WIDTH'(dst_q);
      3'd4: rd_data = CTRL_WIDTH'(len_q);
      3'd5: rd_data = CTRL_WIDTH'({16'(LANES), 16'(ELEM_WIDTH)});
      default: rd_data = '0;
    endcase
  end

  // Control slave: one-cycle ack, registered read data, programmable registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_ack_q  <= 1'b0;
      ctrl_miso_q <= '0;
      irq_en      <= 1'b0;
      src_q       <= '0;
      dst_q       <= '0;
      len_q       <= '0;
    end else begin
      ctrl_ack_q  <= ctrl_req;
      ctrl_miso_q <= (ctrl_req && !control_we_o) ? rd_data : '0;
      if (ctrl_wr) begin
        case (reg_idx)
          3'd0: irq_en <= control_mosi_o[1];
          3'd2: if (!busy) src_q <= ADDR_WIDTH'(control_mosi_o);
          3'd3: if (!busy) dst_q <= ADDR_WIDTH'(control_mosi_o);
          3'd4: if (!busy) len_q <= LEN_WIDTH'(control_mosi_o);
          default: ;
        endcase
      end
    end
  end

  // Status flag and level interrupt; a set in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done_q <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      if (done_set)      done_q <= 1'b1;
      else if (done_clr) done_q <= 1'b0;
      irq_q <= done_q & irq_en;
    end
  end

  // Sequencer: read burst with accumulation, then the single result write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      acc       <= '0;
      rd_cyc_q  <= 1'b0;
      rd_addr_q <= '0;
      rd_cti_q  <= 3'b000;
      wr_cyc_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (start) begin
            acc      <= '0;
            beat_cnt <= '0;
            if (len_q == '0) begin
              state <= DONE;
            end else begin
              state     <= READ;
              rd_cyc_q  <= 1'b1;
              rd_addr_q <= src_q;
              rd_cti_q  <= (len_q == LEN_WIDTH'(1)) ? 3'b111 : 3'b010;
            end
          end
        end
        READ: begin
          if (samples_ack_i) begin
            acc <= acc_sum;
            if (last_beat) begin
              state     <= WRITE;
              rd_cyc_q  <= 1'b0;
              rd_addr_q <= '0;
              rd_cti_q  <= 3'b000;
              wr_cyc_q  <= 1'b1;
              wr_addr_q <= dst_q;
              wr_data_q <= acc_sum;
            end else begin
              beat_cnt  <= beat_cnt + LEN_WIDTH'(1);
              rd_addr_q <= rd_addr_q + ADDR_WIDTH'(BEAT_BYTES);
              rd_cti_q  <= (beat_cnt + LEN_WIDTH'(1) == len_q - LEN_WIDTH'(1)) ? 3'b111 : 3'b010;
            end
          end
        end
        WRITE: begin
          if (cache_ack_i) begin
            state     <= DONE;
            wr_cyc_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign control_ack_i    = ctrl_ack_q;
  assign control_miso_i   = ctrl_miso_q;
  assign done_interrupt_o = irq_q;
  assign samples_cyc_o    = rd_cyc_q;
  assign samples_stb_o    = rd_cyc_q;
  assign samples_we_o     = 1'b0;
  assign samples_addr_o   = rd_addr_q;
  assign samples_mosi_o   = '0;
  assign samples_cti_o    = rd_cti_q;
  assign samples_bte_o    = 2'b00;
  assign cache_cyc_o      = wr_cyc_q;
  assign cache_stb_o      = wr_cyc_q;
  assign cache_we_o       = wr_cyc_q;
  assign cache_addr_o     = wr_addr_q;
  assign cache_mosi_o     = wr_data_q;
  assign cache_cti_o      = wr_cyc_q ? 3'b111 : 3'b000;
  assign cache_bte_o      = 2'b00;

endmodule
